eth_txsched: RTL and testbench

Transmit scheduler for the Ethernet TX path. It arbitrates between two frame sources that share the single transmit buffer and frame transmitter: requester 0 is the host DMA frame, requester 1 is the internal setup/loopback frame. For the granted source it converts the byte length into the transmitter's start count, drives the txena/txdone handshake, and reports completion or error. A watchdog resets a transmitter that stops responding.

---
 rtl/eth_txsched_if.sv | 35 +++
 rtl/eth_txsched.sv | 154 +++++++++++++++
 tb/tb_eth_txsched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_txsched_if.sv
// ============================================================================
// Module      : eth_txsched_if
// Description : Requester and transmitter handshake bundle for eth_txsched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface eth_txsched_if;
    logic [1:0]  req;
    logic [10:0] len0;
    logic [10:0] len1;
    logic        skip0;
    logic        skip1;
    logic        txdone;
    logic        txena;
    logic [10:0] txcntb;
    logic        skipb;
    logic        bsel;
    logic        busy;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        txrst;

    modport master (
        output req, len0, len1, skip0, skip1, txdone,
        input  txena, txcntb, skipb, bsel, busy, done, err, txrst
    );

    modport slave (
        input  req, len0, len1, skip0, skip1, txdone,
        output txena, txcntb, skipb, bsel, busy, done, err, txrst
    );
endinterface

`default_nettype wire

// File: rtl/eth_txsched.sv
// ============================================================================
// Module      : eth_txsched
// Description : Round-robin TX scheduler for two frame sources with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_txsched #(
    parameter int MAXLEN = 1514,
    parameter int MINLEN = 60,
    parameter int TMO    = 3000
) (
    input  wire logic     clk,
    input  wire logic     clr,
    eth_txsched_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_REL  = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    localparam int              c_WDW     = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TMO - 1);

    state_t             r_state, w_state;
    logic               r_last,  w_last;
    logic [10:0]        r_len,   w_len;
    logic               r_skip,  w_skip;
    logic [c_WDW-1:0]   r_wdog,  w_wdog;
    logic               r_txena, w_txena;
    logic [10:0]        r_txcntb, w_txcntb;
    logic               r_skipb, w_skipb;
    logic               r_bsel,  w_bsel;
    logic [1:0]         r_done,  w_done;
    logic [1:0]         r_err,   w_err;
    logic               r_txrst, w_txrst;

    logic               w_gnt;
    logic               w_bad;
    logic [10:0]        w_eff;

    // Contention goes to whoever was not granted last; a lone request wins outright.
    assign w_gnt = bus.req[1] & (~bus.req[0] | ~r_last);
    assign w_bad = (r_len == 11'd0) || (r_len > 11'(MAXLEN));
    assign w_eff = (r_len < 11'(MINLEN)) ? 11'(MINLEN) : r_len;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_len    <= '0;
            r_skip   <= 1'b0;
            r_wdog   <= '0;
            r_txena  <= 1'b0;
            r_txcntb <= '0;
            r_skipb  <= 1'b0;
            r_bsel   <= 1'b0;
            r_done   <= 2'b00;
            r_err    <= 2'b00;
            r_txrst  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_last   <= w_last;
            r_len    <= w_len;
            r_skip   <= w_skip;
            r_wdog   <= w_wdog;
            r_txena  <= w_txena;
            r_txcntb <= w_txcntb;
            r_skipb  <= w_skipb;
            r_bsel   <= w_bsel;
            r_done   <= w_done;
            r_err    <= w_err;
            r_txrst  <= w_txrst;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_last   = r_last;
        w_len    = r_len;
        w_skip   = r_skip;
        w_wdog   = r_wdog;
        w_txena  = r_txena;
        w_txcntb = r_txcntb;
        w_skipb  = r_skipb;
        w_bsel   = r_bsel;
        w_done   = 2'b00;
        w_err    = 2'b00;
        w_txrst  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Requesters still see their pulse this cycle and have not yet dropped req.
                if ((|bus.req) && !(|r_done) && !(|r_err)) begin
                    w_bsel  = w_gnt;
                    w_last  = w_gnt;
                    w_len   = w_gnt ? bus.len1  : bus.len0;
                    w_skip  = w_gnt ? bus.skip1 : bus.skip0;
                    w_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_bad) begin
                    w_state = S_FAIL;
                end else begin
                    w_txcntb = 11'(12'd2048 - {1'b0, w_eff});
                    w_skipb  = r_skip;
                    w_txena  = 1'b1;
                    w_wdog   = '0;
                    w_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.txdone) begin
                    w_txena = 1'b0;
                    w_state = S_REL;
                end else if (r_wdog == c_WD_LAST) begin
                    w_txena = 1'b0;
                    w_txrst = 1'b1;
                    w_state = S_FAIL;
                end else begin
                    w_wdog = r_wdog + 1'b1;
                end
            end
            S_REL: begin
                if (!bus.txdone) begin
                    w_done  = r_bsel ? 2'b10 : 2'b01;
                    w_state = S_IDLE;
                end
            end
            S_FAIL: begin
                w_err   = r_bsel ? 2'b10 : 2'b01;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.txena  = r_txena;
    assign bus.txcntb = r_txcntb;
    assign bus.skipb  = r_skipb;
    assign bus.bsel   = r_bsel;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.txrst  = r_txrst;

endmodule

`default_nettype wire

// File: tb/tb_eth_txsched.sv
// ============================================================================
// Module      : tb_eth_txsched
// Description : Directed self-checking bench for eth_txsched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_txsched;

    localparam int c_TMO = 3000;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    eth_txsched_if bus ();

    eth_txsched #(.MAXLEN(1514), .MINLEN(60), .TMO(c_TMO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++;
        if ({bus.txena, bus.txcntb, bus.skipb, bus.bsel, bus.busy, bus.done, bus.err, bus.txrst} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.txena, bus.txcntb, bus.skipb, bus.bsel, bus.busy, bus.done, bus.err, bus.txrst});
        end
        clr = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_contention();
        logic [1:0] src_req;
        bus.len0 = 11'd100;
        bus.len1 = 11'd200;
        bus.req  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic       exp_src;
            exp_src = (i % 2 == 1);
            tick();
            total++;
            if (bus.bsel !== exp_src) begin bad++; $display("FAIL cont_bsel[%0d]: got %b expected %b", i, bus.bsel, exp_src); end
            tick();
            total++;
            if (bus.txcntb !== (exp_src ? 11'd1848 : 11'd1948)) begin
                bad++; $display("FAIL cont_txcntb[%0d]: got %0d expected %0d", i, bus.txcntb, exp_src ? 1848 : 1948);
            end
            bus.txdone = 1'b1;
            tick();
            bus.txdone = 1'b0;
            tick();
            total++;
            if (bus.done !== (exp_src ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL cont_done[%0d]: got %b expected %b", i, bus.done, exp_src ? 2'b10 : 2'b01);
            end
            src_req = bus.req;
            src_req[exp_src] = 1'b0;
            bus.req = src_req;
            tick();
            src_req[exp_src] = 1'b1;
            bus.req = src_req;
        end
        bus.req = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_single();
        bus.len0  = 11'd100;
        bus.skip0 = 1'b0;
        bus.req   = 2'b01;
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.txena !== 1'b0) begin
            bad++; $display("FAIL single_load: got busy=%b txena=%b expected busy=1 txena=0", bus.busy, bus.txena);
        end
        tick();
        total++;
        if (bus.txena !== 1'b1 || bus.txcntb !== 11'd1948 || bus.bsel !== 1'b0 || bus.skipb !== 1'b0) begin
            bad++; $display("FAIL single_start: got txena=%b txcntb=%0d bsel=%b skipb=%b expected 1 1948 0 0",
                            bus.txena, bus.txcntb, bus.bsel, bus.skipb);
        end
        repeat (50) tick();
        total++;
        if (bus.txena !== 1'b1) begin bad++; $display("FAIL single_hold: got txena=%b expected 1", bus.txena); end
        bus.txdone = 1'b1;
        tick();
        total++;
        if (bus.txena !== 1'b0 || bus.done !== 2'b00) begin
            bad++; $display("FAIL single_rel: got txena=%b done=%b expected 0 00", bus.txena, bus.done);
        end
        bus.txdone = 1'b0;
        tick();
        total++;
        if (bus.done !== 2'b01 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL single_done: got done=%b busy=%b expected 01 0", bus.done, bus.busy);
        end
        bus.req = 2'b00;
        tick();
        total++;
        if (bus.done !== 2'b00 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL single_pulse_end: got done=%b busy=%b expected 00 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_pad_skip();
        bus.len1  = 11'd20;
        bus.skip1 = 1'b1;
        bus.req   = 2'b10;
        tick();
        total++;
        if (bus.bsel !== 1'b1) begin bad++; $display("FAIL pad_bsel: got %b expected 1", bus.bsel); end
        tick();
        total++;
        if (bus.txena !== 1'b1 || bus.txcntb !== 11'd1988 || bus.skipb !== 1'b1) begin
            bad++; $display("FAIL pad_start: got txena=%b txcntb=%0d skipb=%b expected 1 1988 1",
                            bus.txena, bus.txcntb, bus.skipb);
        end
        repeat (5) tick();
        bus.txdone = 1'b1;
        tick();
        bus.txdone = 1'b0;
        tick();
        total++;
        if (bus.done !== 2'b10) begin bad++; $display("FAIL pad_done: got %b expected 10", bus.done); end
        bus.req   = 2'b00;
        bus.skip1 = 1'b0;
        tick();
    endtask

    task automatic test_reject();
        logic [10:0] lens [2];
        lens[0] = 11'd0;
        lens[1] = 11'd1515;
        for (int k = 0; k < 2; k++) begin
            bus.len0 = lens[k];
            bus.req  = 2'b01;
            tick();
            tick();
            total++;
            if (bus.txena !== 1'b0 || bus.err !== 2'b00 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL rej_fail_state[%0d]: got txena=%b err=%b busy=%b expected 0 00 1",
                                lens[k], bus.txena, bus.err, bus.busy);
            end
            tick();
            total++;
            if (bus.err !== 2'b01 || bus.txena !== 1'b0 || bus.done !== 2'b00) begin
                bad++; $display("FAIL rej_err[%0d]: got err=%b txena=%b done=%b expected 01 0 00",
                                lens[k], bus.err, bus.txena, bus.done);
            end
            bus.req = 2'b00;
            tick();
            total++;
            if (bus.err !== 2'b00) begin bad++; $display("FAIL rej_err_end[%0d]: got %b expected 00", lens[k], bus.err); end
        end
    endtask

    task automatic test_timeout();
        bus.len0 = 11'd100;
        bus.req  = 2'b01;
        tick();
        tick();
        total++;
        if (bus.txena !== 1'b1) begin bad++; $display("FAIL tmo_start: got txena=%b expected 1", bus.txena); end
        repeat (c_TMO - 1) tick();
        total++;
        if (bus.txena !== 1'b1 || bus.txrst !== 1'b0) begin
            bad++; $display("FAIL tmo_early: got txena=%b txrst=%b expected 1 0", bus.txena, bus.txrst);
        end
        tick();
        total++;
        if (bus.txena !== 1'b0 || bus.txrst !== 1'b1 || bus.err !== 2'b00) begin
            bad++; $display("FAIL tmo_txrst: got txena=%b txrst=%b err=%b expected 0 1 00", bus.txena, bus.txrst, bus.err);
        end
        tick();
        total++;
        if (bus.err !== 2'b01 || bus.txrst !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL tmo_err: got err=%b txrst=%b busy=%b expected 01 0 0", bus.err, bus.txrst, bus.busy);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        bus.len0 = 11'd300;
        bus.req  = 2'b01;
        tick();
        tick();
        total++;
        if (bus.txena !== 1'b1 || bus.txcntb !== 11'd1748) begin
            bad++; $display("FAIL ar_start: got txena=%b txcntb=%0d expected 1 1748", bus.txena, bus.txcntb);
        end
        #2;
        clr = 1'b1;
        #1;
        total++;
        if ({bus.txena, bus.txcntb, bus.skipb, bus.bsel, bus.busy, bus.done, bus.err, bus.txrst} !== 19'd0) begin
            bad++; $display("FAIL ar_immediate: got %h expected 0",
                            {bus.txena, bus.txcntb, bus.skipb, bus.bsel, bus.busy, bus.done, bus.err, bus.txrst});
        end
        bus.req = 2'b00;
        tick();
        total++;
        if (bus.done !== 2'b00 || bus.err !== 2'b00) begin
            bad++; $display("FAIL ar_no_pulse: got done=%b err=%b expected 00 00", bus.done, bus.err);
        end
        clr      = 1'b0;
        bus.len0 = 11'd100;
        bus.req  = 2'b01;
        tick();
        tick();
        total++;
        if (bus.txena !== 1'b1 || bus.txcntb !== 11'd1948 || bus.bsel !== 1'b0) begin
            bad++; $display("FAIL ar_restart: got txena=%b txcntb=%0d bsel=%b expected 1 1948 0",
                            bus.txena, bus.txcntb, bus.bsel);
        end
        bus.txdone = 1'b1;
        tick();
        bus.txdone = 1'b0;
        tick();
        total++;
        if (bus.done !== 2'b01) begin bad++; $display("FAIL ar_done: got %b expected 01", bus.done); end
        bus.req = 2'b00;
        tick();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        clr        = 1'b1;
        bus.req    = 2'b00;
        bus.len0   = 11'd0;
        bus.len1   = 11'd0;
        bus.skip0  = 1'b0;
        bus.skip1  = 1'b0;
        bus.txdone = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_pad_skip();
        test_reject();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
